// File: rtl/immgen_pkg.sv
// Shared immediate-format definitions for the decode stage.
// Pure combinational helpers: opcode-to-format decode and immediate assembly.
// No state; all timing lives in the modules that import this package.
package immgen_pkg;

    typedef enum logic [2:0] {
        IMM_S    = 3'b000,
        IMM_B    = 3'b001,
        IMM_J    = 3'b010,
        IMM_I    = 3'b011,
        IMM_Z    = 3'b100,
        IMM_SH   = 3'b101,
        IMM_U    = 3'b110,
        IMM_NONE = 3'b111
    } imm_sel_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    // Returns {sel[2:0], illegal}. Register-register and fence opcodes are
    // legal but carry no immediate, so they map to NONE without flagging.
    function automatic logic [3:0] decode_sel(input logic [31:0] instr, input int xlen);
        imm_sel_e   sel;
        logic       ill;
        logic [2:0] f3;
        sel = IMM_NONE;
        ill = 1'b0;
        f3  = instr[14:12];
        case (instr[6:0])
            OP_LUI, OP_AUIPC: sel = IMM_U;
            OP_JAL:           sel = IMM_J;
            OP_JALR, OP_LOAD: sel = IMM_I;
            OP_IMM: begin
                if (f3 == 3'b001 || f3 == 3'b101) sel = IMM_SH;
                else                              sel = IMM_I;
            end
            OP_IMM32: begin
                // Word-sized ALU ops only exist on RV64.
                if (xlen == 64) begin
                    if (f3 == 3'b001 || f3 == 3'b101) sel = IMM_SH;
                    else                              sel = IMM_I;
                end else begin
                    ill = 1'b1;
                end
            end
            OP_STORE:  sel = IMM_S;
            OP_BRANCH: sel = IMM_B;
            OP_SYSTEM: begin
                if (f3[2]) sel = IMM_Z;
                else       sel = IMM_I;
            end
            OP_OP, OP_OP32, OP_FENCE: sel = IMM_NONE;
            default:   ill = 1'b1;
        endcase
        return {sel, ill};
    endfunction

    // Always builds a 64-bit result; callers keep the low XLEN bits, which is
    // still a correct sign extension for XLEN=32.
    function automatic logic [63:0] build_imm(input logic [31:0] instr, input imm_sel_e sel,
                                              input int xlen);
        logic [63:0] imm;
        imm = '0;
        case (sel)
            IMM_S:  imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:  imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:  imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_I:  imm = {{52{instr[31]}}, instr[31:20]};
            IMM_Z:  imm = {59'b0, instr[19:15]};
            IMM_SH: begin
                if (xlen == 64) imm = {58'b0, instr[25:20]};
                else            imm = {59'b0, instr[24:20]};
            end
            IMM_U:  imm = {{32{instr[31]}}, instr[31:12], 12'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/immgen_skid.sv
// Generic valid/ready pipeline register with optional second (skid) entry.
// Latency: 1 cycle from accept to o_valid.
// Backpressure: SKID=1 -> o_ready = !skid_full (registered); SKID=0 -> o_ready = !o_valid || i_ready.
module immgen_skid #(
    parameter int             W       = 8,
    parameter bit             SKID    = 1'b1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_main_vld;
    logic [W-1:0] r_main_dat;
    logic         w_acc;
    logic         w_xfer;

    assign w_acc   = i_valid && o_ready;
    assign w_xfer  = r_main_vld && i_ready;
    assign o_valid = r_main_vld;
    assign o_data  = r_main_dat;

    generate
        if (SKID) begin : g_skid
            logic         r_skid_vld;
            logic [W-1:0] r_skid_dat;

            // Skid full implies main full, so a free skid slot always means
            // there is somewhere to put an incoming word.
            assign o_ready = !r_skid_vld;

            // Main entry refills from skid first to keep order; new words land in
            // skid only when main is occupied and not draining this cycle.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_main_vld <= 1'b0;
                    r_main_dat <= RST_VAL;
                    r_skid_vld <= 1'b0;
                    r_skid_dat <= RST_VAL;
                end else if (i_flush) begin
                    r_main_vld <= 1'b0;
                    r_skid_vld <= 1'b0;
                end else if (!r_main_vld || w_xfer) begin
                    if (r_skid_vld) begin
                        r_main_vld <= 1'b1;
                        r_main_dat <= r_skid_dat;
                        r_skid_vld <= 1'b0;
                    end else begin
                        r_main_vld <= w_acc;
                        if (w_acc) r_main_dat <= i_data;
                    end
                end else if (w_acc) begin
                    r_skid_vld <= 1'b1;
                    r_skid_dat <= i_data;
                end
            end
        end else begin : g_pass
            assign o_ready = !r_main_vld || i_ready;

            // Single register: load on accept, empty when drained with nothing behind.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_main_vld <= 1'b0;
                    r_main_dat <= RST_VAL;
                end else if (i_flush) begin
                    r_main_vld <= 1'b0;
                end else if (w_acc) begin
                    r_main_vld <= 1'b1;
                    r_main_dat <= i_data;
                end else if (w_xfer) begin
                    r_main_vld <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/immgen_pipe.sv
// Decode-stage immediate generator: format select (external or auto-decoded) plus immediate build.
// Latency: 1 cycle from accept to o_valid.
// Backpressure: valid/ready; SKID=1 sustains one result per cycle with a registered o_ready.
module immgen_pipe #(
    parameter int XLEN     = 32,
    parameter bit AUTO_SEL = 1'b0,
    parameter bit SKID     = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [2:0]      i_imm_sel,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_imm_sel,
    output logic            o_illegal
);
    import immgen_pkg::*;

    // Payload layout: {illegal, sel[2:0], imm[XLEN-1:0]}.
    localparam int            PW      = XLEN + 4;
    localparam logic [PW-1:0] RST_VAL = {1'b0, IMM_NONE, {XLEN{1'b0}}};

    logic [3:0]    w_dec;
    logic [2:0]    w_sel;
    logic          w_illegal;
    logic [63:0]   w_imm_full;
    logic [PW-1:0] w_in_dat;
    logic [PW-1:0] w_out_dat;

    // Pick the format source, then assemble the immediate for that format.
    always_comb begin
        w_dec = decode_sel(i_instr, XLEN);
        if (AUTO_SEL) begin
            w_sel     = w_dec[3:1];
            w_illegal = w_dec[0];
        end else begin
            w_sel     = i_imm_sel;
            w_illegal = 1'b0;
        end
        w_imm_full = build_imm(i_instr, imm_sel_e'(w_sel), XLEN);
    end

    assign w_in_dat = {w_illegal, w_sel, w_imm_full[XLEN-1:0]};

    immgen_skid #(
        .W       (PW),
        .SKID    (SKID),
        .RST_VAL (RST_VAL)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (w_in_dat),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (w_out_dat)
    );

    assign o_illegal = w_out_dat[PW-1];
    assign o_imm_sel = w_out_dat[PW-2:PW-4];
    assign o_imm     = w_out_dat[XLEN-1:0];

endmodule

// File: tb/tb_immgen_pipe.sv
// Bench for immgen_pipe: three configurations side by side, each against a queue-based reference.
// dut0: XLEN=32 external select, skid; dut1: XLEN=64 auto, skid; dut2: XLEN=32 auto, pass-through.
// Directed vectors, a throttled stream, flush, random traffic and an async reset mid-stall.
module tb_immgen_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  sel;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld   [3];
    logic        rdy   [3];
    logic        flush [3];
    logic        ordy  [3];
    logic        ovld  [3];
    logic        oill  [3];
    logic [31:0] instr [3];
    logic [2:0]  isel  [3];
    logic [2:0]  osel  [3];
    logic [31:0] imm_a;
    logic [63:0] imm_b;
    logic [31:0] imm_c;

    exp_t        mq [3][$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          rx [3];
    bit          last_acc [3];
    int          sent;
    int          cyc;
    int          rx0;
    logic [5:0]  rp;

    always #5 clk = ~clk;

    immgen_pipe #(.XLEN(32), .AUTO_SEL(1'b0), .SKID(1'b1)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush[0]), .i_valid(vld[0]), .o_ready(ordy[0]),
        .i_instr(instr[0]), .i_imm_sel(isel[0]), .o_valid(ovld[0]), .i_ready(rdy[0]),
        .o_imm(imm_a), .o_imm_sel(osel[0]), .o_illegal(oill[0]));

    immgen_pipe #(.XLEN(64), .AUTO_SEL(1'b1), .SKID(1'b1)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush[1]), .i_valid(vld[1]), .o_ready(ordy[1]),
        .i_instr(instr[1]), .i_imm_sel(isel[1]), .o_valid(ovld[1]), .i_ready(rdy[1]),
        .o_imm(imm_b), .o_imm_sel(osel[1]), .o_illegal(oill[1]));

    immgen_pipe #(.XLEN(32), .AUTO_SEL(1'b1), .SKID(1'b0)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush[2]), .i_valid(vld[2]), .o_ready(ordy[2]),
        .i_instr(instr[2]), .i_imm_sel(isel[2]), .o_valid(ovld[2]), .i_ready(rdy[2]),
        .o_imm(imm_c), .o_imm_sel(osel[2]), .o_illegal(oill[2]));

    function automatic int xl(int d);
        return (d == 1) ? 64 : 32;
    endfunction

    function automatic bit au(int d);
        return d != 0;
    endfunction

    function automatic bit sk(int d);
        return d != 2;
    endfunction

    function automatic logic [63:0] oimm(int d);
        if (d == 0)      return {32'b0, imm_a};
        else if (d == 1) return imm_b;
        else             return {32'b0, imm_c};
    endfunction

    // Sign-extend the low n bits of x using plain arithmetic.
    function automatic longint sx(longint x, int n);
        longint m;
        longint h;
        m = longint'(1) << n;
        h = longint'(1) << (n - 1);
        x = x & (m - 1);
        return (x ^ h) - h;
    endfunction

    function automatic logic [63:0] ref_imm(logic [31:0] w, int s, int xlen);
        longint u;
        longint v;
        u = longint'({32'b0, w});
        case (s)
            0: v = sx(((u >> 25) << 5) | ((u >> 7) & 31), 12);
            1: v = sx(((u >> 31) << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5)
                      | (((u >> 8) & 15) << 1), 13);
            2: v = sx(((u >> 31) << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11)
                      | (((u >> 21) & 1023) << 1), 21);
            3: v = sx(u >> 20, 12);
            4: v = (u >> 15) & 31;
            5: v = (u >> 20) & ((xlen == 64) ? 63 : 31);
            6: v = sx(u & 64'hFFFFF000, 32);
            default: v = 0;
        endcase
        if (xlen == 32) v = v & 64'hFFFFFFFF;
        return 64'(v);
    endfunction

    function automatic exp_t ref_model(int d, logic [31:0] w, logic [2:0] s_in);
        exp_t r;
        int   s;
        bit   ill;
        int   f3;
        s   = 7;
        ill = 1'b0;
        f3  = int'(w[14:12]);
        if (!au(d)) begin
            s = int'(s_in);
        end else begin
            case (w[6:0])
                7'b0110111, 7'b0010111: s = 6;
                7'b1101111:             s = 2;
                7'b1100111, 7'b0000011: s = 3;
                7'b0010011:             s = (f3 == 1 || f3 == 5) ? 5 : 3;
                7'b0011011: begin
                    if (xl(d) == 64) s = (f3 == 1 || f3 == 5) ? 5 : 3;
                    else             ill = 1'b1;
                end
                7'b0100011:             s = 0;
                7'b1100011:             s = 1;
                7'b1110011:             s = (f3 >= 4) ? 4 : 3;
                7'b0110011, 7'b0111011, 7'b0001111: s = 7;
                default:                ill = 1'b1;
            endcase
        end
        r.imm = ref_imm(w, s, xl(d));
        r.sel = 3'(s);
        r.ill = ill;
        return r;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 15))
            0:  w[6:0] = 7'b0110111;
            1:  w[6:0] = 7'b0010111;
            2:  w[6:0] = 7'b1101111;
            3:  w[6:0] = 7'b1100111;
            4:  w[6:0] = 7'b0000011;
            5:  w[6:0] = 7'b0010011;
            6:  w[6:0] = 7'b0011011;
            7:  w[6:0] = 7'b0100011;
            8:  w[6:0] = 7'b1100011;
            9:  w[6:0] = 7'b1110011;
            10: w[6:0] = 7'b0110011;
            11: w[6:0] = 7'b0111011;
            12: w[6:0] = 7'b0001111;
            13: w[6:0] = 7'b1111111;
            default: ;
        endcase
        return w;
    endfunction

    task automatic chk(string tag, int d, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
        end
    endtask

    task automatic chk_reset(string tag);
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_vld"}, d, 64'(ovld[d]), 64'(0));
            chk({tag, "_imm"}, d, oimm(d), 64'(0));
            chk({tag, "_sel"}, d, 64'(osel[d]), 64'(7));
            chk({tag, "_ill"}, d, 64'(oill[d]), 64'(0));
        end
    endtask

    // Check every DUT against its model, advance the model, then move to the next negedge.
    task automatic tick();
        #1;
        for (int d = 0; d < 3; d++) begin
            bit   er;
            bit   acc;
            bit   xf;
            exp_t e;
            er = sk(d) ? (mq[d].size() < 2) : (mq[d].size() == 0 || rdy[d] == 1'b1);
            chk("o_ready", d, 64'(ordy[d]), 64'(er));
            chk("o_valid", d, 64'(ovld[d]), 64'(mq[d].size() > 0));
            if (mq[d].size() > 0) begin
                e = mq[d][0];
                chk("o_imm", d, oimm(d), e.imm);
                chk("o_imm_sel", d, 64'(osel[d]), 64'(e.sel));
                chk("o_illegal", d, 64'(oill[d]), 64'(e.ill));
            end
            acc = (vld[d] == 1'b1) && er;
            xf  = (mq[d].size() > 0) && (rdy[d] == 1'b1);
            last_acc[d] = acc && (flush[d] != 1'b1);
            if (flush[d] == 1'b1) begin
                mq[d].delete();
            end else begin
                if (xf) begin
                    void'(mq[d].pop_front());
                    rx[d]++;
                end
                if (acc) mq[d].push_back(ref_model(d, instr[d], isel[d]));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        for (int d = 0; d < 3; d++) begin
            vld[d]   = 1'b0;
            rdy[d]   = 1'b1;
            flush[d] = 1'b0;
        end
    endtask

    task automatic put(int d, logic [31:0] w, logic [2:0] s);
        vld[d]   = 1'b1;
        instr[d] = w;
        isel[d]  = s;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            instr[d] = '0;
            isel[d]  = '0;
            rx[d]    = 0;
        end
        idle();

        // Reset state
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        tick();

        // Directed formats, one result per cycle with ready held high
        put(0, 32'hFFF00093, 3'b011);
        put(1, 32'h080000EF, 3'b000);
        put(2, 32'h34075073, 3'b000);
        tick();
        chk("lit_I", 0, oimm(0), 64'h00000000FFFFFFFF);
        chk("lit_jal_sel", 1, 64'(osel[1]), 64'(2));
        chk("lit_jal_imm", 1, oimm(1), 64'h0000000000000080);
        chk("lit_csrrwi_sel", 2, 64'(osel[2]), 64'(4));
        chk("lit_csrrwi_imm", 2, oimm(2), 64'd14);
        put(0, 32'hFFF00093, 3'b110);
        put(1, 32'h0050909B, 3'b000);
        put(2, 32'h0000007F, 3'b000);
        tick();
        chk("lit_U", 0, oimm(0), 64'h00000000FFF00000);
        chk("lit_slliw_sel", 1, 64'(osel[1]), 64'(5));
        chk("lit_slliw_imm", 1, oimm(1), 64'd5);
        chk("lit_bad_sel", 2, 64'(osel[2]), 64'(7));
        chk("lit_bad_imm", 2, oimm(2), 64'd0);
        chk("lit_bad_ill", 2, 64'(oill[2]), 64'(1));
        vld[0] = 1'b0;
        put(1, 32'h34075073, 3'b000);
        put(2, 32'h0050909B, 3'b000);
        tick();
        chk("lit_zimm64", 1, oimm(1), 64'd14);
        chk("lit_imm32_rv32_ill", 2, 64'(oill[2]), 64'(1));
        put(1, 32'h0000007F, 3'b000);
        put(2, 32'h34071073, 3'b000);
        tick();
        chk("lit_bad64_ill", 1, 64'(oill[1]), 64'(1));
        chk("lit_csrrw_imm", 2, oimm(2), 64'h340);
        idle();
        tick();
        tick();

        // Six-word stream on dut0 with ready pattern 1,0,0,1,1,0 then released
        rp   = 6'b011001;
        sent = 0;
        cyc  = 0;
        rx0  = rx[0];
        while (cyc < 40) begin
            vld[0]   = (sent < 6);
            instr[0] = rnd_instr();
            isel[0]  = 3'($urandom_range(0, 7));
            rdy[0]   = (cyc < 6) ? rp[cyc] : 1'b1;
            tick();
            if (last_acc[0]) sent++;
            cyc++;
        end
        chk("stream_sent", 0, 64'(sent), 64'(6));
        chk("stream_rcvd", 0, 64'(rx[0] - rx0), 64'(6));
        idle();

        // Flush while both entries of dut0 are held
        rdy[0] = 1'b0;
        put(0, rnd_instr(), 3'b011);
        tick();
        put(0, rnd_instr(), 3'b000);
        tick();
        chk("full_ready", 0, 64'(ordy[0]), 64'(0));
        flush[0] = 1'b1;
        put(0, rnd_instr(), 3'b110);
        tick();
        flush[0] = 1'b0;
        vld[0]   = 1'b0;
        chk("flush_vld", 0, 64'(ovld[0]), 64'(0));
        chk("flush_rdy", 0, 64'(ordy[0]), 64'(1));
        rdy[0] = 1'b1;
        tick();
        tick();

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 3; d++) begin
                vld[d]   = ($urandom_range(0, 3) != 0);
                rdy[d]   = ($urandom_range(0, 3) != 0);
                flush[d] = ($urandom_range(0, 31) == 0);
                instr[d] = rnd_instr();
                isel[d]  = 3'($urandom_range(0, 7));
            end
            tick();
        end
        idle();
        repeat (3) tick();

        // Async reset while stalled with words in flight
        for (int d = 0; d < 3; d++) begin
            put(d, rnd_instr(), 3'($urandom_range(0, 7)));
            rdy[d] = 1'b0;
        end
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        for (int d = 0; d < 3; d++) mq[d].delete();
        idle();
        @(posedge clk);
        @(negedge clk);
        chk_reset("held_rst");
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) put(d, rnd_instr(), 3'($urandom_range(0, 7)));
        tick();
        for (int d = 0; d < 3; d++) chk("post_rst_vld", d, 64'(ovld[d]), 64'(1));
        idle();
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
